// File: rtl/stupidrv_pkg.sv
// rtl/stupidrv_pkg.sv - shared types, defaults and address decode for the stupidrv memory arbiter
package stupidrv_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_DATA_DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_MMIO,
        DEC_FAULT
    } dec_e;

    localparam logic [31:0] OUT_ADDR_DEFAULT   = 32'h0200_0000;
    localparam logic [31:0] FAULT_INSN_DEFAULT = 32'h0000_0000;

    // RAM wins over MMIO so a misconfigured OUT_ADDR inside RAM still reaches memory.
    function automatic dec_e decode_addr(input logic [31:0] addr, input int aw,
                                         input logic [31:0] out_addr);
        dec_e res;
        if ((addr >> aw) == 32'd0) begin
            res = DEC_RAM;
        end else if (addr == out_addr) begin
            res = DEC_MMIO;
        end else begin
            res = DEC_FAULT;
        end
        return res;
    endfunction

endpackage

// File: rtl/stupidrv_mem_arbiter_if.sv
// rtl/stupidrv_mem_arbiter_if.sv - core, RAM and MMIO signal bundle around the memory arbiter
interface stupidrv_mem_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 16
);
    logic                      ext_stall;
    logic                      core_stall;
    logic [31:0]               imem_addr;
    logic [31:0]               imem_data;
    logic                      dmem_valid;
    logic [31:0]               dmem_addr;
    logic [3:0]                dmem_wstrb;
    logic [31:0]               dmem_wdata;
    logic [31:0]               dmem_rdata;
    logic                      ram_en;
    logic [MEM_ADDR_WIDTH-3:0] ram_addr;
    logic [3:0]                ram_wstrb;
    logic [31:0]               ram_wdata;
    logic [31:0]               ram_rdata;
    logic [31:0]               out_data;
    logic                      out_valid;
    logic                      fault;
    logic [31:0]               fault_addr;

    modport master (
        output ext_stall, imem_addr, dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata, ram_rdata,
        input  core_stall, imem_data, dmem_rdata, ram_en, ram_addr, ram_wstrb, ram_wdata,
               out_data, out_valid, fault, fault_addr
    );

    modport slave (
        input  ext_stall, imem_addr, dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata, ram_rdata,
        output core_stall, imem_data, dmem_rdata, ram_en, ram_addr, ram_wstrb, ram_wdata,
               out_data, out_valid, fault, fault_addr
    );

endinterface

// File: rtl/stupidrv_mem_arbiter.sv
// rtl/stupidrv_mem_arbiter.sv - shares one single-port RAM between fetch and data, decodes MMIO and faults
module stupidrv_mem_arbiter
    import stupidrv_pkg::*;
#(
    parameter int          MEM_ADDR_WIDTH = 16,
    parameter logic [31:0] OUT_ADDR       = OUT_ADDR_DEFAULT,
    parameter logic [31:0] FAULT_INSN     = FAULT_INSN_DEFAULT
) (
    input logic                   clock,
    input logic                   reset,
    stupidrv_mem_arbiter_if.slave bus
);

    arb_state_e state_q, state_d;

    logic [31:0] hold_q;
    logic [31:0] out_data_q;
    logic        out_valid_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic        data_issue_q;
    logic        dmem_rd_q;
    logic        fetch_ok_q;

    dec_e d_dec;
    logic fetch_ok;
    logic d_ram;
    logic d_mmio;
    logic d_fault;

    logic                      ram_en;
    logic [MEM_ADDR_WIDTH-3:0] ram_addr;
    logic [3:0]                ram_wstrb;
    logic                      core_stall;
    logic                      accept;
    logic                      data_issue;

    assign d_dec    = decode_addr(bus.dmem_addr, MEM_ADDR_WIDTH, OUT_ADDR);
    assign fetch_ok = (decode_addr(bus.imem_addr, MEM_ADDR_WIDTH, OUT_ADDR) == DEC_RAM);
    assign d_ram    = bus.dmem_valid && (d_dec == DEC_RAM);
    assign d_mmio   = bus.dmem_valid && (d_dec == DEC_MMIO);
    assign d_fault  = bus.dmem_valid && (d_dec == DEC_FAULT);

    always_comb begin
        state_d    = state_q;
        ram_en     = 1'b0;
        ram_addr   = bus.imem_addr[MEM_ADDR_WIDTH-1:2];
        ram_wstrb  = 4'b0000;
        core_stall = 1'b0;
        accept     = 1'b0;
        data_issue = 1'b0;
        if (reset) begin
            if (bus.ext_stall) begin
                core_stall = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (d_ram) begin
                            ram_en     = 1'b1;
                            ram_addr   = bus.dmem_addr[MEM_ADDR_WIDTH-1:2];
                            ram_wstrb  = bus.dmem_wstrb;
                            core_stall = 1'b1;
                            data_issue = 1'b1;
                            state_d    = ST_DATA_DONE;
                        end else begin
                            ram_en = fetch_ok;
                            accept = 1'b1;
                        end
                    end
                    ST_DATA_DONE: begin
                        ram_en  = fetch_ok;
                        accept  = 1'b1;
                        state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= 32'd0;
            out_data_q   <= 32'd0;
            out_valid_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            data_issue_q <= 1'b0;
            dmem_rd_q    <= 1'b0;
            fetch_ok_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_issue_q <= data_issue;
            out_valid_q  <= 1'b0;
            fault_q      <= 1'b0;
            // RAM data is only valid right after the data op, so capture once even if held off.
            if (data_issue_q) begin
                hold_q <= bus.ram_rdata;
            end
            if (accept) begin
                fetch_ok_q <= fetch_ok;
                dmem_rd_q  <= d_ram && (bus.dmem_wstrb == 4'b0000);
                if (d_mmio && (bus.dmem_wstrb != 4'b0000)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.dmem_wstrb[b]) begin
                            out_data_q[8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
                        end
                    end
                    out_valid_q <= 1'b1;
                end
                if (d_fault || !fetch_ok) begin
                    fault_q      <= 1'b1;
                    fault_addr_q <= d_fault ? bus.dmem_addr : bus.imem_addr;
                end
            end
        end
    end

    assign bus.core_stall = core_stall;
    assign bus.ram_en     = ram_en;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_wstrb  = ram_wstrb;
    assign bus.ram_wdata  = bus.dmem_wdata;
    assign bus.imem_data  = fetch_ok_q ? bus.ram_rdata : FAULT_INSN;
    assign bus.dmem_rdata = dmem_rd_q ? hold_q : 32'd0;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

endmodule

// File: doc/stupidrv_mem_arbiter.md
Name: stupidrv_mem_arbiter

Overview:
Shares one single-port, 1-cycle-latency synchronous RAM between the stupidrv instruction-fetch and data ports. It also decodes the output MMIO word and flags out-of-range accesses. Data accesses to RAM cost one core stall cycle. Instruction fetches and MMIO writes run at full rate. The block sits between the stupidrv core and the RAM macro in the SoC top.

Parameters:
MEM_ADDR_WIDTH, 16, byte-address width of RAM (RAM holds 2^(MEM_ADDR_WIDTH-2) words)
OUT_ADDR, 32'h02000000, byte address of the output MMIO word
FAULT_INSN, 32'h00000000, word returned for an out-of-range fetch

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset  in  1  synchronous, active-low reset
ext_stall  in  1  external hold request (debug/bus); when 1, no new access is issued
core_stall  out  1  stall to core
imem_addr  in  32  core fetch byte address
imem_data  out  32  fetched word
dmem_valid  in  1  core data request
dmem_addr  in  32  data byte address
dmem_wstrb  in  4  byte write strobes; 0 = read
dmem_wdata  in  32  write data
dmem_rdata  out  32  read data
ram_en  out  1  RAM access enable
ram_addr  out  MEM_ADDR_WIDTH-2  RAM word address
ram_wstrb  out  4  RAM byte write enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en
out_data  out  32  MMIO output word
out_valid  out  1  one-cycle pulse on an MMIO write
fault  out  1  one-cycle pulse on an out-of-range access
fault_addr  out  32  offending byte address

Behaviour:
- Core contract:
  - A cycle with core_stall=0 is "accepted".
  - Responses (imem_data, dmem_rdata) are valid only in the cycle after an accepted cycle.
  - During core_stall=1 the core holds all request signals stable and ignores responses.
- Decode:
  - RAM hit = dmem_addr[31:2] < 2^(MEM_ADDR_WIDTH-2).
  - MMIO hit = dmem_addr == OUT_ADDR.
  - Anything else is a fault.
  - A fetch is in range iff imem_addr < 2^MEM_ADDR_WIDTH.
- FSM states: IDLE, DATA_DONE.
- IDLE, ext_stall=0:
  - No dmem request, or a non-RAM dmem request: issue fetch (ram_en=1 if fetch in range, ram_addr=imem_addr word, wstrb=0); core_stall=0.
  - RAM dmem request: issue the data op (ram_addr=dmem word, ram_wstrb=dmem_wstrb, ram_wdata=dmem_wdata); core_stall=1; go to DATA_DONE.
- DATA_DONE, ext_stall=0:
  - Capture ram_rdata into the data hold register.
  - Issue fetch; core_stall=0; go to IDLE.
  - The data op is never reissued.
- ext_stall=1 in any state: ram_en=0, core_stall=1, state and hold register frozen. In DATA_DONE the RAM result is captured before freezing.
- Response muxing, in the cycle after an accepted cycle:
  - imem_data = ram_rdata if the fetch was in range, else FAULT_INSN.
  - dmem_rdata = hold register for a RAM read; 0 for writes, MMIO and faults.
- MMIO write:
  - Applies in the accepted cycle, no stall.
  - out_data is updated per strobe byte (unstrobed bytes keep their prior value).
  - out_valid pulses the next cycle.
  - An MMIO read returns 0 with no pulse.
- Fault:
  - Pulses in the cycle after an accepted cycle containing an out-of-range fetch or dmem access.
  - fault_addr is the dmem address if that access faulted, otherwise the fetch address.
  - Faulting writes never reach RAM.
- Reset (reset==0 at an edge):
  - state=IDLE, out_data=0, out_valid=0, fault=0, fault_addr=0, hold=0.
  - While reset is low: ram_en=0, core_stall=0.
- First accepted cycle after reset release issues a normal fetch.
- Reset during DATA_DONE abandons the sequence. The RAM op already issued stands.

Decomposition:
- Shared package stupidrv_pkg holds:
  - the FSM state enum;
  - OUT_ADDR default;
  - FAULT_INSN default;
  - an address-decode function returning {RAM, MMIO, FAULT}.
- No sub-module is needed; the FSM and muxing live in one module.

Test Plan:
- Straight-line fetch, no dmem, imem_addr 0,4,8 -> core_stall stays 0; imem_data equals RAM words 0,1,2 one cycle later.
- Load from 0x100 (RAM holds 0xDEADBEEF) -> core_stall=1 for exactly one cycle; next accepted cycle fetches; dmem_rdata=0xDEADBEEF in the following cycle; exactly one RAM data read.
- Store 0x11223344 to 0x200 with wstrb=4'b0011 -> RAM sees exactly one write with wstrb 0011; a later load returns 0xXXXX3344 merged with the old upper half.
- MMIO store 42 to 0x02000000, wstrb=1111 -> no stall; out_valid pulses once; out_data=42.
- dmem store to 0x00100000 -> fault pulse, fault_addr=0x00100000, ram_wstrb never nonzero.
- ext_stall asserted during DATA_DONE for 3 cycles, then reset low mid-load -> state frozen and load result preserved across ext_stall; after reset, state IDLE and all outputs at reset values.
